// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: start/stop, seconds countdown, LFSR mole spawning,
// per-mole lifetimes, hit/miss detection and a saturating 0..99 score.

module mole_round_lane #(
  parameter int MOLE_LIFE = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic slot,
  input  logic spawn,
  input  logic sw_edge,
  output logic up,
  output logic hit,
  output logic miss
);
  logic [7:0] life;
  logic       expire;

  assign hit    = up & sw_edge;
  assign expire = slot & up & (life == 8'd1);
  // A hit landing on the expiry slot wins, so it is not also a miss.
  assign miss   = expire & ~hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up   <= 1'b0;
      life <= 8'd0;
    end else if (clear) begin
      up   <= 1'b0;
      life <= 8'd0;
    end else if (spawn) begin
      up   <= 1'b1;
      life <= 8'(MOLE_LIFE);
    end else if (hit | expire) begin
      up   <= 1'b0;
    end else if (slot & up) begin
      life <= life - 8'd1;
    end
  end
endmodule

module mole_round_ctrl #(
  parameter int          TICK_DIV   = 100000000,
  parameter int          SPAWN_DIV  = 10000000,
  parameter int          ROUND_SECS = 60,
  parameter int          MOLE_LIFE  = 15,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] sw,
  output logic [3:0] mole,
  output logic [7:0] seconds,
  output logic [7:0] score,
  output logic       round_active,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       score_clear
);
  localparam int NUM_LANES = 4;
  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state, state_nxt;

  logic                 start_s1, start_s2, start_d, start_edge;
  logic [NUM_LANES-1:0] sw_s1, sw_s2, sw_d, sw_edge;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        spawn_cnt;
  logic [15:0]          lfsr;
  logic                 play, go, to_over, tick_wrap, slot;
  logic [NUM_LANES-1:0] spawn_v, hit_v, miss_v, miss_eff;
  logic [2:0]           hits, misses;
  logic signed [8:0]    score_sum;
  logic [7:0]           score_nxt;

  function automatic logic [2:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) c = c + 3'(v[i]);
    return c;
  endfunction

  // Two-flop synchronizers plus a third register for rising-edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_d     <= '0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      sw_d     <= sw_s2;
    end
  end

  assign start_edge = start_s2 & ~start_d;
  assign sw_edge    = sw_s2 & ~sw_d;
  assign play       = (state == PLAY);
  assign tick_wrap  = play & (tick_cnt == TW'(TICK_DIV - 1));
  assign slot       = play & (spawn_cnt == SW'(SPAWN_DIV - 1));

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    to_over   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          go        = 1'b1;
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (tick_wrap && seconds == 8'd1) begin
          to_over   = 1'b1;
          state_nxt = OVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Spawn target is judged against the pre-slot mole vector, so a mole that
  // expires or is hit on this edge cannot come straight back.
  always_comb begin
    spawn_v = '0;
    if (slot && lfsr[3:2] == 2'b00 && !mole[lfsr[1:0]])
      spawn_v[lfsr[1:0]] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mole_round_lane #(.MOLE_LIFE(MOLE_LIFE)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (go | to_over),
      .slot    (slot),
      .spawn   (spawn_v[i]),
      .sw_edge (sw_edge[i] & play),
      .up      (mole[i]),
      .hit     (hit_v[i]),
      .miss    (miss_v[i])
    );
  end

  // Moles swept away by the end of the round are not misses.
  assign miss_eff  = miss_v & {NUM_LANES{~to_over}};
  assign hits      = popcnt(hit_v);
  assign misses    = popcnt(miss_eff);
  assign score_sum = $signed({1'b0, score}) + $signed({6'b0, hits}) - $signed({6'b0, misses});

  always_comb begin
    score_nxt = score_sum[7:0];
    if (score_sum < 9'sd0)       score_nxt = 8'd0;
    else if (score_sum > 9'sd99) score_nxt = 8'd99;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      spawn_cnt   <= '0;
      lfsr        <= LFSR_SEED;
      seconds     <= 8'(ROUND_SECS);
      score       <= 8'd0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      score_clear <= 1'b0;
    end else begin
      state       <= state_nxt;
      hit_pulse   <= |hit_v;
      miss_pulse  <= |miss_eff;
      score_clear <= go;

      if (go || state_nxt != PLAY) begin
        tick_cnt  <= '0;
        spawn_cnt <= '0;
      end else begin
        tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
        spawn_cnt <= slot ? '0 : spawn_cnt + 1'b1;
      end

      if (slot) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (go)             seconds <= 8'(ROUND_SECS);
      else if (tick_wrap) seconds <= seconds - 8'd1;

      if (go)        score <= 8'd0;
      else if (play) score <= score_nxt;
    end
  end

  assign round_active = (state == PLAY);
  assign game_over    = (state == OVER);
endmodule
